multi_cycle_controller: RTL and testbench
=========================================

MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 Parameter XLEN, 32, data width and retire-counter width; value comes from Parameters.vh.
REQ-002 clk  in  1  the single clock; all state changes on the rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 opcode  in  7  instruction opcode from the instruction decoder.
REQ-005 memReady  in  1  memory handshake; the access completes on an edge where memReq=1 and memReady=1.
REQ-006 branchTaken  in  1  ALU branch comparison result; sampled in EXECUTE only.
REQ-007 memReq  out  1  memory access request.
REQ-008 memWe  out  1  write strobe; valid only with memReq.
REQ-009 memAddrSel  out  1  memory address source: 0 = PC, 1 = ALU result.
REQ-010 irWrite  out  1  instruction register load strobe.
REQ-011 pcWrite  out  1  PC update strobe.
REQ-012 pcSel  out  2  PC source: 0 = PC+4, 1 = PC+imm (branch/JAL), 2 = rs1+imm (JALR).
REQ-013 regWrite  out  1  register file write strobe.
REQ-014 wbSel  out  2  writeback source: 0 = ALU, 1 = memory data, 2 = PC+4.
REQ-015 aluOp  out  2  ALU mode: 0 = add, 1 = branch compare, 2 = funct decode.
REQ-016 illegalInstr  out  1  sticky illegal-opcode flag.
REQ-017 retireCount  out  XLEN  count of retired instructions.
REQ-018 state  out  3  current state, for debug.

Function
REQ-019 Control outputs SHALL be combinational from the registered state, the latched class, memReady and branchTaken; state, class and counter are registered.
REQ-020 State encoding SHALL be FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, HALT=5; any other value SHALL go to FETCH on the next edge.
REQ-021 FETCH: memReq=1, memAddrSel=0, memWe=0; remain while memReady=0; when memReady=1, irWrite=1 that cycle and next state is DECODE.
REQ-022 DECODE: latch the instruction class from opcode. Legal opcodes are LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011 and OP 0110011; these go to EXECUTE; any other opcode goes to HALT.
REQ-023 EXECUTE aluOp: BRANCH = 1; OP and OP-IMM = 2; all others = 0.
REQ-024 EXECUTE transitions: LOAD/STORE go to MEMORY; BRANCH retires with pcWrite=1 and pcSel = branchTaken ? 1 : 0, then goes to FETCH; all other classes go to WRITEBACK.
REQ-025 MEMORY: memReq=1, memAddrSel=1, memWe=1 for STORE only; remain while memReady=0.
REQ-026 MEMORY completion (memReady=1): STORE retires with pcWrite=1, pcSel=0, then goes to FETCH; LOAD goes to WRITEBACK.
REQ-027 WRITEBACK: regWrite=1 and pcWrite=1 for exactly one cycle, then FETCH. wbSel = 1 for LOAD, 2 for JAL/JALR, 0 otherwise. pcSel = 1 for JAL, 2 for JALR, 0 otherwise.
REQ-028 A retire cycle is any cycle with pcWrite=1; retireCount SHALL increment by 1 on that edge and wrap from 2^XLEN-1 to 0.
REQ-029 HALT: illegalInstr=1; all other strobes 0; no exit except reset.
REQ-030 Strobes irWrite, pcWrite and regWrite SHALL never be asserted for more than one cycle per instruction.
REQ-031 memReq SHALL never be asserted in DECODE, EXECUTE, WRITEBACK or HALT.
REQ-032 Latency with memReady always 1: BRANCH 3 cycles; OP, OP-IMM, LUI, AUIPC, JAL, JALR and STORE 4 cycles; LOAD 5 cycles.
REQ-033 Each memory wait cycle adds exactly one cycle to the latency.

Reset
REQ-034 While rst=1, all outputs SHALL be 0, including memReq.
REQ-035 An edge with rst=1 SHALL set state=FETCH, class=0, retireCount=0 and illegalInstr=0.
REQ-036 Reset asserted mid-access (memReq=1, memReady=0) SHALL drop memReq immediately and abandon the access; no retire is counted.
REQ-037 The first cycle after rst falls SHALL be FETCH with memReq=1.

Verification
REQ-038 Run OP 0110011 with memReady=1 -> state sequence 0,1,2,4,0; regWrite=1 and pcWrite=1 in cycle 4 only; retireCount goes 0 -> 1.
REQ-039 Run LOAD with memReady=0 for 3 cycles in MEMORY -> memReq held 4 cycles with memAddrSel=1 and memWe=0; then wbSel=1; instruction retires after 8 cycles.
REQ-040 Run BRANCH twice, first with branchTaken=1 then with branchTaken=0 -> pcSel=1 then pcSel=0, each retiring in EXECUTE; regWrite stays 0; retireCount increases by 2.
REQ-041 Apply opcode 1111111 -> HALT reached after DECODE; illegalInstr=1 held for 20 cycles; no memReq; rst then clears everything to 0.
REQ-042 Force retireCount to 0xFFFFFFFF and retire a JALR -> count becomes 0x00000000; pcSel=2 and wbSel=2 in WRITEBACK.
REQ-043 Assert rst during FETCH wait (memReady=0) -> memReq=0 in the same cycle; after rst releases, state=0 and memReq=1.

Source files
------------

// File: rtl/multi_cycle_controller.sv
// multi_cycle_controller
//
// Purpose:
//   Control FSM for a multi-cycle RV32I-style datapath. Walks each
//   instruction through FETCH -> DECODE -> EXECUTE -> (MEMORY) ->
//   (WRITEBACK) and drives the datapath strobes and mux selects.
//   Control outputs are combinational from the registered state, the
//   latched instruction class, memReady and branchTaken.
//
// Ports:
//   clk          in   single clock, rising-edge active
//   rst          in   synchronous active-high reset
//   opcode       in   [6:0] instruction opcode from the decoder
//   memReady     in   memory handshake; an access completes on an edge
//                     where memReq=1 and memReady=1
//   branchTaken  in   ALU branch comparison result (used in EXECUTE)
//   memReq       out  memory access request
//   memWe        out  memory write strobe (only with memReq)
//   memAddrSel   out  memory address source: 0 = PC, 1 = ALU result
//   irWrite      out  instruction register load strobe
//   pcWrite      out  PC update strobe (marks a retire cycle)
//   pcSel        out  [1:0] PC source: 0 = PC+4, 1 = PC+imm, 2 = rs1+imm
//   regWrite     out  register file write strobe
//   wbSel        out  [1:0] writeback source: 0 = ALU, 1 = mem, 2 = PC+4
//   aluOp        out  [1:0] ALU mode: 0 = add, 1 = branch cmp, 2 = funct
//   illegalInstr out  sticky illegal-opcode flag (held in HALT)
//   retireCount  out  [XLEN-1:0] retired instruction count, wraps
//   state        out  [2:0] current state, for debug

module multi_cycle_controller #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [6:0]      opcode,
    input  logic            memReady,
    input  logic            branchTaken,
    output logic            memReq,
    output logic            memWe,
    output logic            memAddrSel,
    output logic            irWrite,
    output logic            pcWrite,
    output logic [1:0]      pcSel,
    output logic            regWrite,
    output logic [1:0]      wbSel,
    output logic [1:0]      aluOp,
    output logic            illegalInstr,
    output logic [XLEN-1:0] retireCount,
    output logic [2:0]      state
);

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEMORY    = 3'd3,
        WRITEBACK = 3'd4,
        HALT      = 3'd5
    } stateT;

    typedef enum logic [3:0] {
        CLS_NONE   = 4'd0,
        CLS_LUI    = 4'd1,
        CLS_AUIPC  = 4'd2,
        CLS_JAL    = 4'd3,
        CLS_JALR   = 4'd4,
        CLS_BRANCH = 4'd5,
        CLS_LOAD   = 4'd6,
        CLS_STORE  = 4'd7,
        CLS_OPIMM  = 4'd8,
        CLS_OP     = 4'd9
    } classT;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    stateT            stateReg;
    stateT            nextState;
    classT            classReg;
    classT            opClass;
    logic [XLEN-1:0]  retireCnt;

    logic             memReqInt;
    logic             memWeInt;
    logic             memAddrSelInt;
    logic             irWriteInt;
    logic             pcWriteInt;
    logic [1:0]       pcSelInt;
    logic             regWriteInt;
    logic [1:0]       wbSelInt;
    logic [1:0]       aluOpInt;
    logic             illegalInt;

    // Map the raw opcode onto an instruction class. Anything not in the
    // supported set comes out as CLS_NONE, which DECODE treats as illegal.
    always_comb begin
        opClass = CLS_NONE;
        case (opcode)
            OPC_LUI:    opClass = CLS_LUI;
            OPC_AUIPC:  opClass = CLS_AUIPC;
            OPC_JAL:    opClass = CLS_JAL;
            OPC_JALR:   opClass = CLS_JALR;
            OPC_BRANCH: opClass = CLS_BRANCH;
            OPC_LOAD:   opClass = CLS_LOAD;
            OPC_STORE:  opClass = CLS_STORE;
            OPC_OPIMM:  opClass = CLS_OPIMM;
            OPC_OP:     opClass = CLS_OP;
            default:    opClass = CLS_NONE;
        endcase
    end

    // State, class and retire counter registers. The class is captured only
    // in DECODE so later states see a stable value even if the opcode bus
    // moves. Every cycle with pcWrite high is a retire and bumps the counter,
    // which wraps naturally at 2^XLEN.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg  <= FETCH;
            classReg  <= CLS_NONE;
            retireCnt <= '0;
        end else begin
            stateReg <= nextState;
            if (stateReg == DECODE) begin
                classReg <= opClass;
            end
            if (pcWriteInt) begin
                retireCnt <= retireCnt + XLEN'(1);
            end
        end
    end

    // Next-state and control decode. Everything defaults to idle so any
    // state not listed (including unused encodings 6 and 7) drives no
    // strobes and falls back to FETCH. Holding rst forces every control
    // output low in the same cycle, which is how an in-flight memory access
    // gets abandoned without a retire.
    always_comb begin
        nextState     = FETCH;
        memReqInt     = 1'b0;
        memWeInt      = 1'b0;
        memAddrSelInt = 1'b0;
        irWriteInt    = 1'b0;
        pcWriteInt    = 1'b0;
        pcSelInt      = 2'd0;
        regWriteInt   = 1'b0;
        wbSelInt      = 2'd0;
        aluOpInt      = 2'd0;
        illegalInt    = 1'b0;

        if (!rst) begin
            case (stateReg)
                FETCH: begin
                    memReqInt = 1'b1;
                    if (memReady) begin
                        irWriteInt = 1'b1;
                        nextState  = DECODE;
                    end else begin
                        nextState  = FETCH;
                    end
                end

                DECODE: begin
                    nextState = (opClass == CLS_NONE) ? HALT : EXECUTE;
                end

                EXECUTE: begin
                    case (classReg)
                        CLS_BRANCH:       aluOpInt = 2'd1;
                        CLS_OP, CLS_OPIMM: aluOpInt = 2'd2;
                        default:          aluOpInt = 2'd0;
                    endcase
                    case (classReg)
                        CLS_LOAD, CLS_STORE: nextState = MEMORY;
                        CLS_BRANCH: begin
                            pcWriteInt = 1'b1;
                            pcSelInt   = branchTaken ? 2'd1 : 2'd0;
                            nextState  = FETCH;
                        end
                        default: nextState = WRITEBACK;
                    endcase
                end

                MEMORY: begin
                    memReqInt     = 1'b1;
                    memAddrSelInt = 1'b1;
                    memWeInt      = (classReg == CLS_STORE);
                    if (memReady) begin
                        if (classReg == CLS_STORE) begin
                            pcWriteInt = 1'b1;
                            pcSelInt   = 2'd0;
                            nextState  = FETCH;
                        end else begin
                            nextState  = WRITEBACK;
                        end
                    end else begin
                        nextState = MEMORY;
                    end
                end

                WRITEBACK: begin
                    regWriteInt = 1'b1;
                    pcWriteInt  = 1'b1;
                    case (classReg)
                        CLS_LOAD:          wbSelInt = 2'd1;
                        CLS_JAL, CLS_JALR: wbSelInt = 2'd2;
                        default:           wbSelInt = 2'd0;
                    endcase
                    case (classReg)
                        CLS_JAL:  pcSelInt = 2'd1;
                        CLS_JALR: pcSelInt = 2'd2;
                        default:  pcSelInt = 2'd0;
                    endcase
                    nextState = FETCH;
                end

                HALT: begin
                    illegalInt = 1'b1;
                    nextState  = HALT;
                end

                default: begin
                    nextState = FETCH;
                end
            endcase
        end
    end

    // Drive the ports. The debug state and counter views also read as zero
    // while rst is held so the whole interface is quiet during reset.
    assign memReq       = memReqInt;
    assign memWe        = memWeInt;
    assign memAddrSel   = memAddrSelInt;
    assign irWrite      = irWriteInt;
    assign pcWrite      = pcWriteInt;
    assign pcSel        = pcSelInt;
    assign regWrite     = regWriteInt;
    assign wbSel        = wbSelInt;
    assign aluOp        = aluOpInt;
    assign illegalInstr = illegalInt;
    assign retireCount  = rst ? '0 : retireCnt;
    assign state        = rst ? 3'd0 : stateReg;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// tb_multi_cycle_controller
//
// Purpose:
//   Directed self-checking bench for multi_cycle_controller. Inputs change
//   1 ns after each rising edge and outputs are compared 1 ns later, well
//   away from the next edge. Expected values are hand-derived from the
//   state walk of each instruction class.
//
// Ports: none (top-level bench).

module tb_multi_cycle_controller;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BAD    = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode;
    logic        memReady;
    logic        branchTaken;
    logic        memReq;
    logic        memWe;
    logic        memAddrSel;
    logic        irWrite;
    logic        pcWrite;
    logic [1:0]  pcSel;
    logic        regWrite;
    logic [1:0]  wbSel;
    logic [1:0]  aluOp;
    logic        illegalInstr;
    logic [31:0] retireCount;
    logic [2:0]  state;

    int totalChecks = 0;
    int badChecks   = 0;

    multi_cycle_controller #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .memReady     (memReady),
        .branchTaken  (branchTaken),
        .memReq       (memReq),
        .memWe        (memWe),
        .memAddrSel   (memAddrSel),
        .irWrite      (irWrite),
        .pcWrite      (pcWrite),
        .pcSel        (pcSel),
        .regWrite     (regWrite),
        .wbSel        (wbSel),
        .aluOp        (aluOp),
        .illegalInstr (illegalInstr),
        .retireCount  (retireCount),
        .state        (state)
    );

    // 100 MHz free-running clock.
    always #5 clk = ~clk;

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Count one comparison and report it if observed differs from expected.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", tag, observed, expected);
        end
    endtask

    // Drive the input pins and let the combinational outputs settle.
    task automatic applyStimulus(input logic [6:0] op, input logic rdy, input logic br);
        opcode      = op;
        memReady    = rdy;
        branchTaken = br;
        #1;
    endtask

    // Advance to 1 ns past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Walk FETCH and DECODE for an opcode with memReady=1.
    task automatic fetchDecode(input logic [6:0] op);
        applyStimulus(op, 1'b1, 1'b0);
        checkOutput("fetch.state", 64'(state), 64'd0);
        checkOutput("fetch.irWrite", 64'(irWrite), 64'd1);
        tick();
        applyStimulus(op, 1'b1, 1'b0);
        checkOutput("decode.state", 64'(state), 64'd1);
        checkOutput("decode.memReq", 64'(memReq), 64'd0);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(7'd0, 1'b0, 1'b0);
        tick();
        tick();

        // Reset state: everything quiet even with memReady high.
        applyStimulus(OPC_OP, 1'b1, 1'b1);
        checkOutput("rst.state", 64'(state), 64'd0);
        checkOutput("rst.memReq", 64'(memReq), 64'd0);
        checkOutput("rst.irWrite", 64'(irWrite), 64'd0);
        checkOutput("rst.retire", 64'(retireCount), 64'd0);
        checkOutput("rst.illegal", 64'(illegalInstr), 64'd0);

        // First cycle after release is FETCH requesting memory.
        rst = 1'b0;
        applyStimulus(OPC_OP, 1'b1, 1'b0);
        checkOutput("post.memReq", 64'(memReq), 64'd1);
        checkOutput("post.addrSel", 64'(memAddrSel), 64'd0);

        // OP: 0,1,2,4,0 with the retire in cycle 4.
        fetchDecode(OPC_OP);
        applyStimulus(OPC_OP, 1'b1, 1'b0);
        checkOutput("op.exec.state", 64'(state), 64'd2);
        checkOutput("op.exec.aluOp", 64'(aluOp), 64'd2);
        checkOutput("op.exec.pcWrite", 64'(pcWrite), 64'd0);
        tick();
        checkOutput("op.wb.state", 64'(state), 64'd4);
        checkOutput("op.wb.regWrite", 64'(regWrite), 64'd1);
        checkOutput("op.wb.pcWrite", 64'(pcWrite), 64'd1);
        checkOutput("op.wb.wbSel", 64'(wbSel), 64'd0);
        checkOutput("op.wb.retire", 64'(retireCount), 64'd0);
        tick();
        checkOutput("op.done.state", 64'(state), 64'd0);
        checkOutput("op.done.regWrite", 64'(regWrite), 64'd0);
        checkOutput("op.done.retire", 64'(retireCount), 64'd1);

        // LOAD with three memory wait cycles: 8 cycles total.
        fetchDecode(OPC_LOAD);
        checkOutput("ld.exec.aluOp", 64'(aluOp), 64'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(OPC_LOAD, 1'b0, 1'b0);
            checkOutput("ld.wait.state", 64'(state), 64'd3);
            checkOutput("ld.wait.memReq", 64'(memReq), 64'd1);
            checkOutput("ld.wait.addrSel", 64'(memAddrSel), 64'd1);
            checkOutput("ld.wait.memWe", 64'(memWe), 64'd0);
            tick();
        end
        applyStimulus(OPC_LOAD, 1'b1, 1'b0);
        checkOutput("ld.mem.memReq", 64'(memReq), 64'd1);
        checkOutput("ld.mem.pcWrite", 64'(pcWrite), 64'd0);
        tick();
        checkOutput("ld.wb.state", 64'(state), 64'd4);
        checkOutput("ld.wb.wbSel", 64'(wbSel), 64'd1);
        checkOutput("ld.wb.pcWrite", 64'(pcWrite), 64'd1);
        tick();
        checkOutput("ld.done.retire", 64'(retireCount), 64'd2);

        // STORE retires in MEMORY with the write strobe.
        fetchDecode(OPC_STORE);
        tick();
        applyStimulus(OPC_STORE, 1'b1, 1'b0);
        checkOutput("st.mem.state", 64'(state), 64'd3);
        checkOutput("st.mem.memWe", 64'(memWe), 64'd1);
        checkOutput("st.mem.pcWrite", 64'(pcWrite), 64'd1);
        checkOutput("st.mem.regWrite", 64'(regWrite), 64'd0);
        tick();
        checkOutput("st.done.state", 64'(state), 64'd0);
        checkOutput("st.done.retire", 64'(retireCount), 64'd3);

        // BRANCH taken then not taken, each retiring in EXECUTE.
        fetchDecode(OPC_BRANCH);
        applyStimulus(OPC_BRANCH, 1'b1, 1'b1);
        checkOutput("brT.aluOp", 64'(aluOp), 64'd1);
        checkOutput("brT.pcWrite", 64'(pcWrite), 64'd1);
        checkOutput("brT.pcSel", 64'(pcSel), 64'd1);
        checkOutput("brT.regWrite", 64'(regWrite), 64'd0);
        tick();
        checkOutput("brT.done.state", 64'(state), 64'd0);
        checkOutput("brT.done.retire", 64'(retireCount), 64'd4);
        fetchDecode(OPC_BRANCH);
        applyStimulus(OPC_BRANCH, 1'b1, 1'b0);
        checkOutput("brN.pcWrite", 64'(pcWrite), 64'd1);
        checkOutput("brN.pcSel", 64'(pcSel), 64'd0);
        checkOutput("brN.regWrite", 64'(regWrite), 64'd0);
        tick();
        checkOutput("brN.done.retire", 64'(retireCount), 64'd5);

        // Preload the counter to all-ones and retire a JALR to see it wrap.
        force dut.retireCnt = 32'hFFFF_FFFF;
        #1;
        release dut.retireCnt;
        checkOutput("jalr.preload", 64'(retireCount), 64'hFFFF_FFFF);
        fetchDecode(OPC_JALR);
        checkOutput("jalr.exec.aluOp", 64'(aluOp), 64'd0);
        tick();
        checkOutput("jalr.wb.pcSel", 64'(pcSel), 64'd2);
        checkOutput("jalr.wb.wbSel", 64'(wbSel), 64'd2);
        checkOutput("jalr.wb.retire", 64'(retireCount), 64'hFFFF_FFFF);
        tick();
        checkOutput("jalr.wrap", 64'(retireCount), 64'd0);

        // JAL and LUI writeback selects.
        fetchDecode(OPC_JAL);
        tick();
        checkOutput("jal.wb.pcSel", 64'(pcSel), 64'd1);
        checkOutput("jal.wb.wbSel", 64'(wbSel), 64'd2);
        tick();
        fetchDecode(OPC_LUI);
        tick();
        checkOutput("lui.wb.pcSel", 64'(pcSel), 64'd0);
        checkOutput("lui.wb.wbSel", 64'(wbSel), 64'd0);
        checkOutput("lui.wb.regWrite", 64'(regWrite), 64'd1);
        tick();
        checkOutput("lui.done.retire", 64'(retireCount), 64'd2);

        // Illegal opcode: HALT after DECODE, sticky and silent for 20 cycles.
        fetchDecode(OPC_BAD);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(OPC_OP, 1'b1, 1'b1);
            checkOutput("halt.state", 64'(state), 64'd5);
            checkOutput("halt.illegal", 64'(illegalInstr), 64'd1);
            checkOutput("halt.memReq", 64'(memReq), 64'd0);
            checkOutput("halt.pcWrite", 64'(pcWrite), 64'd0);
            tick();
        end
        checkOutput("halt.retire", 64'(retireCount), 64'd2);
        rst = 1'b1;
        applyStimulus(OPC_OP, 1'b1, 1'b0);
        checkOutput("halt.rst.illegal", 64'(illegalInstr), 64'd0);
        tick();
        rst = 1'b0;
        applyStimulus(OPC_OP, 1'b0, 1'b0);
        checkOutput("halt.clr.state", 64'(state), 64'd0);
        checkOutput("halt.clr.illegal", 64'(illegalInstr), 64'd0);
        checkOutput("halt.clr.retire", 64'(retireCount), 64'd0);

        // Reset during a FETCH wait drops memReq at once; no retire counted.
        checkOutput("fw.memReq", 64'(memReq), 64'd1);
        tick();
        applyStimulus(OPC_OP, 1'b0, 1'b0);
        checkOutput("fw.hold.state", 64'(state), 64'd0);
        checkOutput("fw.hold.irWrite", 64'(irWrite), 64'd0);
        rst = 1'b1;
        #1;
        checkOutput("fw.rst.memReq", 64'(memReq), 64'd0);
        tick();
        rst = 1'b0;
        applyStimulus(OPC_OP, 1'b1, 1'b0);
        checkOutput("fw.rel.state", 64'(state), 64'd0);
        checkOutput("fw.rel.memReq", 64'(memReq), 64'd1);
        checkOutput("fw.rel.retire", 64'(retireCount), 64'd0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
